pll_start_seq: RTL and testbench
================================

# pll_start_seq

Start-up sequencer for the PLL, clocked on the reference clock. It sits directly downstream of the synchronous reset generator: that generator's synchronized release drives this block's NARST. The block then steps the loop through DCO enable, coarse band calibration, loop settling and lock. It raises SEQ_DONE on success or SEQ_FAIL on calibration timeout.

## Interface
- W_CNT, 8, width of the shared phase counter and of all cycle-count inputs
- CLK  in  1  reference clock; all state updates on the falling edge
- NARST  in  1  asynchronous active-low reset; driven by the synchronized reset release
- START  in  1  level request; 1 runs the sequence, 0 aborts it or returns to idle
- CAL_DONE  in  1  coarse-calibration complete, from the band-cal block, sampled on the falling edge
- DCO_WAIT_CYC  in  W_CNT  DCO warm-up length in cycles; 0 is treated as 1
- CAL_TMO_CYC  in  W_CNT  calibration timeout in cycles; 0 is treated as 1
- SETTLE_CYC  in  W_CNT  loop settle length in cycles; 0 is treated as 1
- DCO_EN  out  1  DCO enable
- CAL_EN  out  1  coarse-calibration enable
- LOOP_EN  out  1  closed-loop enable
- SEQ_DONE  out  1  sequence completed
- SEQ_FAIL  out  1  calibration timed out
- STATE  out  3  current state code

## Operation
- States and codes: IDLE=0, DCOW=1, CAL=2, SETTLE=3, LOCKED=4, FAIL=5. Codes 6 and 7 are illegal and return to IDLE on the next edge.
- All outputs are registered and decoded from the next state, so each output changes on the same edge as STATE.
- Output levels per state:
  - IDLE: all outputs 0
  - DCOW: DCO_EN=1
  - CAL: DCO_EN=1, CAL_EN=1
  - SETTLE: DCO_EN=1, LOOP_EN=1
  - LOCKED: DCO_EN=1, LOOP_EN=1, SEQ_DONE=1
  - FAIL: SEQ_FAIL=1 only
- Transitions:
  - IDLE -> DCOW when START=1.
  - DCOW -> CAL after max(DCO_WAIT_CYC,1) cycles in DCOW.
  - CAL -> SETTLE when CAL_DONE=1.
  - CAL -> FAIL after max(CAL_TMO_CYC,1) cycles in CAL without CAL_DONE (see Configuration).
  - SETTLE -> LOCKED after max(SETTLE_CYC,1) cycles in SETTLE.
  - LOCKED and FAIL hold while START=1.
- START=0 in any non-IDLE state returns the block to IDLE on the next edge. Abort has priority over every other transition.
- CAL_DONE and timeout on the same edge: CAL_DONE wins, and the next state is SETTLE.
- Phase counter:
  - One W_CNT-bit counter, cleared to 0 on every state entry.
  - It increments each cycle inside a timed state. A phase ends when counter equals limit-1, where limit is the effective value (0 mapped to 1).
  - The counter never wraps: the phase ends at the 2^W_CNT-1 maximum.
- Cycle-count inputs are sampled live. Software holds them static while START=1; the behaviour is undefined otherwise.

## Timing
- Reset values: STATE=0, counter=0, all outputs 0. NARST assertion clears everything asynchronously, mid-sequence included.
- Release: the first falling edge with NARST=1 may accept START.
- START latency: START=1 sampled at edge k gives DCO_EN=1 just after edge k.
- DCOW length: CAL_EN rises at edge k+N, where N is the effective DCO_WAIT_CYC.
- CAL_DONE latency: CAL_DONE=1 at edge m drops CAL_EN and raises LOOP_EN at edge m.
- SETTLE length: SEQ_DONE rises S edges after LOOP_EN rises, where S is the effective SETTLE_CYC.
- Abort latency: START=0 at edge a gives all outputs 0 after edge a (one edge).

## Configuration
- PLL_START_SEQ_TIMEOUT_EN defined:
  - CAL uses CAL_TMO_CYC as described above, and FAIL is reachable.
- PLL_START_SEQ_TIMEOUT_EN undefined:
  - CAL waits for CAL_DONE indefinitely, and CAL_TMO_CYC is ignored.
  - FAIL is unreachable and SEQ_FAIL is tied to 0.
  - The counter is idle in CAL.

## Test plan
- Nominal run: W_CNT=8, DCO_WAIT_CYC=4, SETTLE_CYC=3, START=1 at edge 10, CAL_DONE pulsed at edge 20 -> DCO_EN at 10, CAL_EN 14..19, LOOP_EN from 20, SEQ_DONE from 23, STATE sequence 1,2,3,4.
- Timeout (macro on): CAL_TMO_CYC=5, CAL_DONE held 0 -> SEQ_FAIL=1 five edges after CAL entry, STATE=5, all enables 0; START=0 then gives IDLE in one edge.
- Tie: CAL_TMO_CYC=5 and CAL_DONE=1 on the fifth CAL edge -> STATE=3, SEQ_FAIL never 1.
- Zero counts: DCO_WAIT_CYC=0, SETTLE_CYC=0 -> DCOW and SETTLE each last exactly 1 cycle.
- Abort and reset: START=0 during SETTLE -> all outputs 0 after one edge. Separately, NARST pulsed low mid-CAL -> immediate clear, and a fresh START restarts from DCOW.
- Macro off: CAL_DONE withheld for 300 cycles -> STATE stays 2, SEQ_FAIL stays 0.

Source files
------------

// File: rtl/pll_start_seq.sv
// pll_start_seq: PLL start-up sequencer (DCO warm-up, band cal, settle, lock); CAL timeout under PLL_START_SEQ_TIMEOUT_EN
module pll_start_seq #(
    parameter int W_CNT = 8
) (
    input  logic             CLK,
    input  logic             NARST,
    input  logic             START,
    input  logic             CAL_DONE,
    input  logic [W_CNT-1:0] DCO_WAIT_CYC,
    input  logic [W_CNT-1:0] CAL_TMO_CYC,
    input  logic [W_CNT-1:0] SETTLE_CYC,
    output logic             DCO_EN,
    output logic             CAL_EN,
    output logic             LOOP_EN,
    output logic             SEQ_DONE,
    output logic             SEQ_FAIL,
    output logic [2:0]       STATE
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DCOW   = 3'd1;
    localparam logic [2:0] CAL    = 3'd2;
    localparam logic [2:0] SETTLE = 3'd3;
    localparam logic [2:0] LOCKED = 3'd4;
    localparam logic [2:0] FAIL   = 3'd5;
    logic [2:0]       state_q, state_d;
    logic [W_CNT-1:0] cnt_q, cnt_d, lim_raw, lim;
    logic             last, timed;
    logic             dco_en_q, cal_en_q, loop_en_q, seq_done_q, seq_fail_q;
    logic             dco_en_d, cal_en_d, loop_en_d, seq_done_d, seq_fail_d;
    always_comb begin
        lim_raw = state_q == DCOW ? DCO_WAIT_CYC : state_q == CAL ? CAL_TMO_CYC : SETTLE_CYC;
        lim     = lim_raw == '0 ? W_CNT'(1) : lim_raw;
        last    = (cnt_q == lim - 1'b1) || (&cnt_q);
`ifdef PLL_START_SEQ_TIMEOUT_EN
        timed   = state_q == DCOW || state_q == CAL || state_q == SETTLE;
`else
        timed   = state_q == DCOW || state_q == SETTLE;
`endif
        state_d = state_q;
        case (state_q)
            IDLE:   state_d = START ? DCOW : IDLE;
            DCOW:   state_d = last ? CAL : DCOW;
`ifdef PLL_START_SEQ_TIMEOUT_EN
            CAL:    state_d = CAL_DONE ? SETTLE : last ? FAIL : CAL;
`else
            CAL:    state_d = CAL_DONE ? SETTLE : CAL;
`endif
            SETTLE: state_d = last ? LOCKED : SETTLE;
            LOCKED: state_d = LOCKED;
            FAIL:   state_d = FAIL;
            default: state_d = IDLE;
        endcase
        // abort overrides every other transition
        if (!START && state_q != IDLE) state_d = IDLE;
        cnt_d      = state_d != state_q ? '0 : timed ? cnt_q + 1'b1 : cnt_q;
        dco_en_d   = state_d == DCOW || state_d == CAL || state_d == SETTLE || state_d == LOCKED;
        cal_en_d   = state_d == CAL;
        loop_en_d  = state_d == SETTLE || state_d == LOCKED;
        seq_done_d = state_d == LOCKED;
`ifdef PLL_START_SEQ_TIMEOUT_EN
        seq_fail_d = state_d == FAIL;
`else
        seq_fail_d = 1'b0;
`endif
    end
    always_ff @(negedge CLK or negedge NARST) begin
        if (!NARST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dco_en_q   <= 1'b0;
            cal_en_q   <= 1'b0;
            loop_en_q  <= 1'b0;
            seq_done_q <= 1'b0;
            seq_fail_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dco_en_q   <= dco_en_d;
            cal_en_q   <= cal_en_d;
            loop_en_q  <= loop_en_d;
            seq_done_q <= seq_done_d;
            seq_fail_q <= seq_fail_d;
        end
    end
    assign STATE    = state_q;
    assign DCO_EN   = dco_en_q;
    assign CAL_EN   = cal_en_q;
    assign LOOP_EN  = loop_en_q;
    assign SEQ_DONE = seq_done_q;
    assign SEQ_FAIL = seq_fail_q;
endmodule

// File: tb/tb_pll_start_seq.sv
// tb_pll_start_seq: directed bench for pll_start_seq (outputs packed as {DCO,CAL,LOOP,DONE,FAIL})
module tb_pll_start_seq;
    logic       CLK = 1'b1;
    logic       NARST = 1'b0;
    logic       START = 1'b0;
    logic       CAL_DONE = 1'b0;
    logic [7:0] DCO_WAIT_CYC = 8'd4;
    logic [7:0] CAL_TMO_CYC = 8'd20;
    logic [7:0] SETTLE_CYC = 8'd3;
    logic       DCO_EN, CAL_EN, LOOP_EN, SEQ_DONE, SEQ_FAIL;
    logic [2:0] STATE;
    int         n_vec = 0;
    int         n_err = 0;
    pll_start_seq #(.W_CNT(8)) dut (
        .CLK(CLK), .NARST(NARST), .START(START), .CAL_DONE(CAL_DONE),
        .DCO_WAIT_CYC(DCO_WAIT_CYC), .CAL_TMO_CYC(CAL_TMO_CYC), .SETTLE_CYC(SETTLE_CYC),
        .DCO_EN(DCO_EN), .CAL_EN(CAL_EN), .LOOP_EN(LOOP_EN),
        .SEQ_DONE(SEQ_DONE), .SEQ_FAIL(SEQ_FAIL), .STATE(STATE)
    );
    always #5 CLK = ~CLK;
    function automatic logic [4:0] outs();
        return {DCO_EN, CAL_EN, LOOP_EN, SEQ_DONE, SEQ_FAIL};
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(negedge CLK);
        #1;
    endtask
    task automatic st(input string tag, input logic [2:0] s, input logic [4:0] o);
        chk({tag, "_state"}, 32'(STATE), 32'(s));
        chk({tag, "_outs"}, 32'(outs()), 32'(o));
    endtask
    task automatic to_idle();
        START = 1'b0;
        CAL_DONE = 1'b0;
        step();
        st("idle", 3'd0, 5'b00000);
    endtask
    initial begin
        #2;
        st("reset", 3'd0, 5'b00000);
        step();
        st("reset_hold", 3'd0, 5'b00000);
        NARST = 1'b1;
        step();
        st("release_idle", 3'd0, 5'b00000);
        // nominal: START at edge k, CAL_EN at k+4, CAL_DONE 6 CAL edges later, SEQ_DONE 3 edges after LOOP_EN
        START = 1'b1;
        step();
        st("nom_dcow", 3'd1, 5'b10000);
        for (int i = 0; i < 3; i++) begin
            step();
            st("nom_dcow_hold", 3'd1, 5'b10000);
        end
        step();
        st("nom_cal", 3'd2, 5'b11000);
        for (int i = 0; i < 5; i++) begin
            step();
            st("nom_cal_hold", 3'd2, 5'b11000);
        end
        CAL_DONE = 1'b1;
        step();
        st("nom_settle", 3'd3, 5'b10100);
        CAL_DONE = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            st("nom_settle_hold", 3'd3, 5'b10100);
        end
        step();
        st("nom_locked", 3'd4, 5'b10110);
        step();
        st("nom_locked_hold", 3'd4, 5'b10110);
        to_idle();
`ifdef PLL_START_SEQ_TIMEOUT_EN
        CAL_TMO_CYC = 8'd5;
        START = 1'b1;
        repeat (5) step();
        st("tmo_cal", 3'd2, 5'b11000);
        for (int i = 0; i < 4; i++) begin
            step();
            st("tmo_cal_hold", 3'd2, 5'b11000);
        end
        step();
        st("tmo_fail", 3'd5, 5'b00001);
        step();
        st("tmo_fail_hold", 3'd5, 5'b00001);
        to_idle();
`endif
        // tie between CAL_DONE and the fifth CAL edge
        CAL_TMO_CYC = 8'd5;
        START = 1'b1;
        repeat (5) step();
        st("tie_cal", 3'd2, 5'b11000);
        repeat (4) step();
        CAL_DONE = 1'b1;
        step();
        st("tie_settle", 3'd3, 5'b10100);
        CAL_DONE = 1'b0;
        to_idle();
        // zero counts behave as one
        DCO_WAIT_CYC = 8'd0;
        SETTLE_CYC = 8'd0;
        CAL_TMO_CYC = 8'd20;
        START = 1'b1;
        step();
        st("zero_dcow", 3'd1, 5'b10000);
        step();
        st("zero_cal", 3'd2, 5'b11000);
        CAL_DONE = 1'b1;
        step();
        st("zero_settle", 3'd3, 5'b10100);
        CAL_DONE = 1'b0;
        step();
        st("zero_locked", 3'd4, 5'b10110);
        to_idle();
        // abort during SETTLE
        DCO_WAIT_CYC = 8'd2;
        SETTLE_CYC = 8'd3;
        START = 1'b1;
        repeat (3) step();
        CAL_DONE = 1'b1;
        step();
        CAL_DONE = 1'b0;
        st("abort_settle", 3'd3, 5'b10100);
        step();
        START = 1'b0;
        step();
        st("abort_idle", 3'd0, 5'b00000);
        // async reset mid-CAL, then restart
        START = 1'b1;
        repeat (4) step();
        st("rst_cal", 3'd2, 5'b11000);
        #2 NARST = 1'b0;
        #1;
        st("rst_async", 3'd0, 5'b00000);
        #1 NARST = 1'b1;
        step();
        st("rst_restart", 3'd1, 5'b10000);
        to_idle();
`ifndef PLL_START_SEQ_TIMEOUT_EN
        CAL_TMO_CYC = 8'd5;
        START = 1'b1;
        repeat (3) step();
        st("noto_cal", 3'd2, 5'b11000);
        for (int i = 0; i < 300; i++) begin
            step();
            if (STATE !== 3'd2 || SEQ_FAIL !== 1'b0 || i == 299) st("noto_wait", 3'd2, 5'b11000);
        end
        to_idle();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
